// File: rtl/serial_adder_full_adder.sv
// One-bit full adder cell: the single arithmetic element of the bit-serial adder.
module FULL_ADDER (
  input  logic FA_A,
  input  logic FA_B,
  input  logic FA_C_0,
  output logic FA_F,
  output logic FA_C_1
);

  logic half_s;

  assign half_s = FA_A ^ FA_B;
  assign FA_F   = half_s ^ FA_C_0;
  assign FA_C_1 = (FA_A & FA_B) | (FA_C_0 & half_s);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: operands shift LSB-first through one FULL_ADDER,
// one bit per clock, with the carry held in a register between bits.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             SA_START,
  input  logic [WIDTH-1:0] SA_A,
  input  logic [WIDTH-1:0] SA_B,
  input  logic             SA_C_IN,
  output logic             SA_BUSY,
  output logic             SA_DONE,
  output logic [WIDTH-1:0] SA_SUM,
  output logic             SA_C_OUT
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [1:0]       state_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] a_sr_r;
  logic [WIDTH-1:0] b_sr_r;
  logic [WIDTH-1:0] s_sr_r;
  logic             carry_r;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] sum_r;
  logic             c_out_r;

  logic             fa_sum_s;
  logic             fa_carry_s;
  logic             accept_s;
  logic             last_s;
  logic [WIDTH-1:0] s_next_s;

  FULL_ADDER u_full_adder (
    .FA_A   (a_sr_r[0]),
    .FA_B   (b_sr_r[0]),
    .FA_C_0 (carry_r),
    .FA_F   (fa_sum_s),
    .FA_C_1 (fa_carry_s)
  );

  // The newest sum bit enters at the MSB so bit 0 lands in the LSB after WIDTH shifts.
  generate
    if (WIDTH == 1) begin : g_sum_w1
      assign s_next_s = fa_sum_s;
    end else begin : g_sum_wn
      assign s_next_s = {fa_sum_s, s_sr_r[WIDTH-1:1]};
    end
  endgenerate

  // Start is honoured only when no addition is in flight (IDLE or DONE).
  always_comb begin
    accept_s = 1'b0;
    last_s   = 1'b0;
    if ((state_r == ST_IDLE) || (state_r == ST_DONE)) begin
      accept_s = SA_START;
    end else if (state_r == ST_RUN) begin
      last_s = (cnt_r == CNT_LAST);
    end else begin
      accept_s = 1'b0;
    end
  end

  // Control sequencing: state, bit counter and the busy/done flags.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r <= ST_IDLE;
      cnt_r   <= CNT_ZERO;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          done_r <= 1'b0;
          if (accept_s) begin
            state_r <= ST_RUN;
            cnt_r   <= CNT_ZERO;
            busy_r  <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        end
        ST_RUN: begin
          if (last_s) begin
            state_r <= ST_DONE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= CNT_ZERO;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  // Datapath: operand/sum shift registers, carry, and the held result.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      a_sr_r  <= '0;
      b_sr_r  <= '0;
      s_sr_r  <= '0;
      carry_r <= 1'b0;
      sum_r   <= '0;
      c_out_r <= 1'b0;
    end else if (accept_s) begin
      a_sr_r  <= SA_A;
      b_sr_r  <= SA_B;
      carry_r <= SA_C_IN;
    end else if (state_r == ST_RUN) begin
      a_sr_r  <= a_sr_r >> 1'b1;
      b_sr_r  <= b_sr_r >> 1'b1;
      s_sr_r  <= s_next_s;
      carry_r <= fa_carry_s;
      if (last_s) begin
        sum_r   <= s_next_s;
        c_out_r <= fa_carry_s;
      end else begin
        sum_r   <= sum_r;
        c_out_r <= c_out_r;
      end
    end else begin
      a_sr_r <= a_sr_r;
    end
  end

  assign SA_BUSY  = busy_r;
  assign SA_DONE  = done_r;
  assign SA_SUM   = sum_r;
  assign SA_C_OUT = c_out_r;

endmodule

// File: tb/tb_serial_adder.sv
// Randomized self-checking bench for serial_adder at WIDTH=8 and WIDTH=1,
// checked against plain integer addition.
module tb_serial_adder;

  logic       clk;
  logic       rst;
  logic       start8;
  logic [7:0] a8;
  logic [7:0] b8;
  logic       c8;
  logic       busy8;
  logic       done8;
  logic [7:0] sum8;
  logic       cout8;

  logic       start1;
  logic [0:0] a1;
  logic [0:0] b1;
  logic       c1;
  logic       busy1;
  logic       done1;
  logic [0:0] sum1;
  logic       cout1;

  int n_checks;
  int n_errors;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .CLK      (clk),
    .RST      (rst),
    .SA_START (start8),
    .SA_A     (a8),
    .SA_B     (b8),
    .SA_C_IN  (c8),
    .SA_BUSY  (busy8),
    .SA_DONE  (done8),
    .SA_SUM   (sum8),
    .SA_C_OUT (cout8)
  );

  serial_adder #(.WIDTH(1)) u_dut1 (
    .CLK      (clk),
    .RST      (rst),
    .SA_START (start1),
    .SA_A     (a1),
    .SA_B     (b1),
    .SA_C_IN  (c1),
    .SA_BUSY  (busy1),
    .SA_DONE  (done1),
    .SA_SUM   (sum1),
    .SA_C_OUT (cout1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the accepting edge.
  task automatic launch8(input logic [7:0] a, input logic [7:0] b, input logic cin);
    start8 = 1'b1;
    a8 = a;
    b8 = b;
    c8 = cin;
    @(negedge clk);
    start8 = 1'b0;
    a8 = 8'($urandom);
    b8 = 8'($urandom);
    c8 = 1'($urandom);
  endtask

  // Watches the 8 RUN cycles, then checks the DONE cycle against the reference.
  task automatic expect8(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic cin, input bit poke);
    int busy_n;
    int done_n;
    logic [8:0] ref_v;
    busy_n = 0;
    done_n = 0;
    ref_v = 9'(a) + 9'(b) + 9'(cin);
    for (int i = 0; i < 8; i++) begin
      if (busy8) busy_n++;
      if (done8) done_n++;
      if (poke && i == 2) begin
        start8 = 1'b1;
        a8 = 8'hAA;
        b8 = 8'h55;
      end else begin
        start8 = 1'b0;
      end
      @(negedge clk);
    end
    start8 = 1'b0;
    check_eq({tag, " busy_cycles"}, 32'(busy_n), 32'd8);
    check_eq({tag, " early_done"}, 32'(done_n), 32'd0);
    check_eq({tag, " done"}, 32'(done8), 32'd1);
    check_eq({tag, " busy_in_done"}, 32'(busy8), 32'd0);
    check_eq({tag, " sum"}, 32'(sum8), 32'(ref_v[7:0]));
    check_eq({tag, " cout"}, 32'(cout8), 32'(ref_v[8]));
  endtask

  task automatic idle_after8(input string tag, input logic [7:0] held);
    @(negedge clk);
    check_eq({tag, " done_pulse_len"}, 32'(done8), 32'd0);
    check_eq({tag, " held_sum"}, 32'(sum8), 32'(held));
  endtask

  initial begin
    logic [7:0] ra;
    logic [7:0] rb;
    logic       rc;
    logic [1:0] ref1;
    logic [7:0] prev;
    int         quiet_done;
    n_checks = 0;
    n_errors = 0;
    start8 = 1'b0; a8 = 8'h00; b8 = 8'h00; c8 = 1'b0;
    start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
    rst = 1'b1;
    #1;
    check_eq("reset busy", 32'(busy8), 32'd0);
    check_eq("reset done", 32'(done8), 32'd0);
    check_eq("reset sum", 32'(sum8), 32'd0);
    check_eq("reset cout", 32'(cout8), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("post_reset busy", 32'(busy8), 32'd0);

    // Directed cases
    launch8(8'h3C, 8'h5A, 1'b0);
    expect8("basic", 8'h3C, 8'h5A, 1'b0, 1'b0);
    check_eq("basic sum_const", 32'(sum8), 32'h96);
    idle_after8("basic", 8'h96);

    launch8(8'hFF, 8'h01, 1'b0);
    expect8("wrap", 8'hFF, 8'h01, 1'b0, 1'b0);
    check_eq("wrap cout_const", 32'(cout8), 32'd1);
    idle_after8("wrap", 8'h00);

    launch8(8'hFF, 8'hFF, 1'b1);
    expect8("allones", 8'hFF, 8'hFF, 1'b1, 1'b0);
    idle_after8("allones", 8'hFF);

    launch8(8'h10, 8'h20, 1'b0);
    expect8("ignore_start", 8'h10, 8'h20, 1'b0, 1'b1);
    check_eq("ignore_start sum_const", 32'(sum8), 32'h30);
    idle_after8("ignore_start", 8'h30);
    check_eq("ignore_start no_rerun", 32'(busy8), 32'd0);

    // Back-to-back: new start driven during the DONE cycle
    launch8(8'h21, 8'h43, 1'b0);
    expect8("b2b_first", 8'h21, 8'h43, 1'b0, 1'b0);
    launch8(8'h01, 8'h02, 1'b0);
    check_eq("b2b held_first", 32'(sum8), 32'h64);
    expect8("b2b_second", 8'h01, 8'h02, 1'b0, 1'b0);
    check_eq("b2b sum_const", 32'(sum8), 32'h03);
    idle_after8("b2b", 8'h03);

    // Asynchronous reset during bit 4
    launch8(8'hA5, 8'h3C, 1'b1);
    for (int i = 0; i < 4; i++) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_eq("midreset busy", 32'(busy8), 32'd0);
    check_eq("midreset done", 32'(done8), 32'd0);
    check_eq("midreset sum", 32'(sum8), 32'd0);
    check_eq("midreset cout", 32'(cout8), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    quiet_done = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done8 || busy8) quiet_done++;
    end
    check_eq("midreset no_done", 32'(quiet_done), 32'd0);
    launch8(8'h7F, 8'h01, 1'b0);
    expect8("after_reset", 8'h7F, 8'h01, 1'b0, 1'b0);
    check_eq("after_reset sum_const", 32'(sum8), 32'h80);
    idle_after8("after_reset", 8'h80);

    // Randomized operands, sometimes back-to-back
    prev = sum8;
    for (int n = 0; n < 24; n++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      if (n % 3 == 0) begin
        ra = (n % 2 == 0) ? 8'hFF : 8'h00;
      end
      launch8(ra, rb, rc);
      check_eq("rand held_prev", 32'(sum8), 32'(prev));
      expect8("rand", ra, rb, rc, 1'($urandom_range(0, 1)));
      prev = 8'(9'(ra) + 9'(rb) + 9'(rc));
      if ($urandom_range(0, 1) == 0) begin
        idle_after8("rand", prev);
        for (int g = $urandom_range(0, 3); g > 0; g--) @(negedge clk);
      end
    end

    // WIDTH=1 exhaustive sweep
    for (int v = 0; v < 8; v++) begin
      start1 = 1'b1;
      a1 = 1'(v >> 2);
      b1 = 1'(v >> 1);
      c1 = 1'(v);
      ref1 = 2'(a1) + 2'(b1) + 2'(c1);
      @(negedge clk);
      start1 = 1'b0;
      a1 = 1'($urandom);
      b1 = 1'($urandom);
      c1 = 1'($urandom);
      check_eq("w1 busy", 32'(busy1), 32'd1);
      check_eq("w1 early_done", 32'(done1), 32'd0);
      @(negedge clk);
      check_eq("w1 done", 32'(done1), 32'd1);
      check_eq("w1 busy_end", 32'(busy1), 32'd0);
      check_eq("w1 sum", 32'(sum1), 32'(ref1[0]));
      check_eq("w1 cout", 32'(cout1), 32'(ref1[1]));
      @(negedge clk);
      check_eq("w1 done_len", 32'(done1), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
